// File: rtl/button_pulse_bank.sv
// Multi-channel key conditioner: synchronizer, debounce counter and press FSM per channel,
// emitting Pressed/Released pulses and a Held level. Define BUTTON_REPEAT_EN for auto-repeat.
module button_pulse_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic button,
    output logic pressed,
    output logic released,
    output logic held
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          AL_BIT   = (ACTIVE_LOW != 0);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_DELAY < 0) begin : g_bad_params
        $error("button_pulse_lane: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   pressed_q, pressed_d;
    logic                   released_q, released_d;
    logic                   held_q, held_d;
    logic                   r;

    // r is the synchronized level normalised so that 1 always means pressed
    assign r = sync_q[SYNC_STAGES-1] ^ AL_BIT;

`ifdef BUTTON_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX + 1);
    logic [RCW-1:0] rep_q, rep_d, rep_target;
    logic           rep_per_q, rep_per_d;
`endif

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], button};
        state_d    = state_q;
        cnt_d      = cnt_q;
        pressed_d  = 1'b0;
        released_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (r) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!r) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (DEBOUNCE_CYCLES == 1 || cnt_q == CNT_LAST) begin
                    state_d   = HELD;
                    pressed_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!r) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d    = IDLE;
                        released_d = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (r) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (DEBOUNCE_CYCLES == 1 || cnt_q == CNT_LAST) begin
                    state_d    = IDLE;
                    released_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == HELD) || (state_d == RELEASE_WAIT);

`ifdef BUTTON_REPEAT_EN
        // Counts toward the initial delay first, then toward each period; frozen in RELEASE_WAIT
        rep_d      = rep_q;
        rep_per_d  = rep_per_q;
        rep_target = rep_per_q ? RCW'(REPEAT_PERIOD) : RCW'(REPEAT_DELAY);
        if (state_q == HELD && r) begin
            if (rep_q + RCW'(1) == rep_target) begin
                pressed_d = 1'b1;
                rep_d     = '0;
                rep_per_d = 1'b1;
            end else begin
                rep_d = rep_q + RCW'(1);
            end
        end else if (state_q == IDLE || state_q == PRESS_WAIT) begin
            rep_d     = '0;
            rep_per_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_q     <= {SYNC_STAGES{AL_BIT}};
            state_q    <= IDLE;
            cnt_q      <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            held_q     <= held_d;
        end
    end

`ifdef BUTTON_REPEAT_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rep_q     <= '0;
            rep_per_q <= 1'b0;
        end else begin
            rep_q     <= rep_d;
            rep_per_q <= rep_per_d;
        end
    end
`endif

    assign pressed  = pressed_q;
    assign released = released_q;
    assign held     = held_q;
endmodule

module button_pulse_bank #(
    parameter int N_BUTTONS       = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [N_BUTTONS-1:0] Buttons,
    output logic [N_BUTTONS-1:0] Pressed,
    output logic [N_BUTTONS-1:0] Released,
    output logic [N_BUTTONS-1:0] Held
);
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_lane
        button_pulse_lane #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_lane (
            .Clock   (Clock),
            .Reset   (Reset),
            .button  (Buttons[i]),
            .pressed (Pressed[i]),
            .released(Released[i]),
            .held    (Held[i])
        );
    end
endmodule

// File: doc/button_pulse_bank.md
Name: button_pulse_bank

Overview:
- Multi-channel successor to the single-key press/one-pulse FSM used on the DE1-SoC KEY inputs.
- Per channel, in this order: metastability synchronizer, counter-based debounce filter, four-state press FSM.
- Outputs per channel: a one-cycle Pressed pulse, a one-cycle Released pulse and a debounced Held level.
- Sits between the raw KEY pins and game/control logic, and replaces per-key instances of the old press detector.

Parameters:
- N_BUTTONS, 4: number of independent channels (minimum 1).
- SYNC_STAGES, 2: synchronizer flops per channel (minimum 2).
- DEBOUNCE_CYCLES, 4: consecutive identical samples required to accept a press or a release (minimum 1).
- ACTIVE_LOW, 1: 1 means pin low = pressed (DE1-SoC KEY); 0 means pin high = pressed.
- REPEAT_DELAY, 50000000: Held cycles before the first auto-repeat pulse (used only with the macro).
- REPEAT_PERIOD, 10000000: cycles between subsequent auto-repeat pulses (used only with the macro; minimum 1).

Ports:
- Clock  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- Buttons  in  N_BUTTONS  raw asynchronous pin levels.
- Pressed  out  N_BUTTONS  one-cycle pulse per accepted press (and per repeat when enabled).
- Released  out  N_BUTTONS  one-cycle pulse per accepted release.
- Held  out  N_BUTTONS  debounced pressed level.

Behaviour:
- Interface: reset Reset, synchronous, active-high; clock Clock.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses; there is no arbitration.
- Synchronizer:
  - Chain of SYNC_STAGES flops per channel.
  - Reset value of each flop is the inactive pin level (1 when ACTIVE_LOW=1).
  - r = last stage XOR ACTIVE_LOW, so r=1 means pressed.
- Debounce counter cnt, width $clog2(DEBOUNCE_CYCLES+1):
  - Counts consecutive samples of r that disagree with the accepted level.
  - Cleared whenever r agrees with the accepted level.
- FSM states and transitions (all edges sample r):
  - IDLE: r=1 -> PRESS_WAIT, cnt=1.
  - PRESS_WAIT:
    - r=0 -> IDLE, cnt=0.
    - r=1 and cnt==DEBOUNCE_CYCLES-1 (or DEBOUNCE_CYCLES==1) -> HELD, Pressed=1 for the next cycle.
    - Otherwise cnt++.
  - HELD: r=0 -> RELEASE_WAIT, cnt=1. With DEBOUNCE_CYCLES==1, go straight to IDLE and pulse Released.
  - RELEASE_WAIT:
    - r=1 -> HELD, cnt=0, no new Pressed.
    - r=0 and count complete -> IDLE, Released=1 for the next cycle.
    - Otherwise cnt++.
- Outputs:
  - Pressed and Released are registered, high exactly one cycle.
  - Held is registered, 1 in HELD and RELEASE_WAIT.
- Latency:
  - Edge 0 = first edge capturing a stable pressed pin.
  - Pressed is high during the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES-1. Defaults: after edge 5.
  - Held rises on that same edge. Release latency is symmetric.
- Glitches:
  - Any bounce shorter than DEBOUNCE_CYCLES samples produces no pulse and no Held change.
  - A press/release toggle pattern never produces two Pressed pulses without an intervening Released.
- Reset:
  - All outputs 0; all FSMs IDLE; counters 0.
  - Reset mid-press aborts with no Released pulse.
  - A key still held after Reset deasserts is reported as a new press after full latency.

Optional Feature:
- Macro: BUTTON_REPEAT_EN.
- Defined:
  - Per-channel repeat counter clears on entering HELD.
  - Counter increments each HELD cycle and freezes in RELEASE_WAIT.
  - Counter clears in IDLE and on Reset.
  - If the first Pressed is cycle t, further Pressed pulses occur at t+REPEAT_DELAY, then every REPEAT_PERIOD cycles, while the channel stays in HELD.
- Undefined:
  - Exactly one Pressed per accepted press.
  - Repeat logic is absent and the repeat parameters are ignored.

Test Plan:
- Defaults, Reset 2 cycles then Buttons=4'b1110 held -> Pressed[0] high one cycle, after edge 5 counted from the first capture edge; Held[0]=1; other channels 0.
- Buttons[1] bounces low/high with 1-, 2- and 3-cycle widths, then returns high -> Pressed[1], Released[1] and Held[1] stay 0 throughout.
- Key 0 held 20 cycles then released cleanly -> exactly one Pressed[0] and one Released[0]; Held[0] falls 5 edges after the release capture.
- Buttons=4'b0000 in one cycle -> Pressed=4'b1111 in the same cycle; then staggered releases -> separate Released pulses.
- Reset asserted one cycle while key 2 is held -> outputs 0 during Reset; Pressed[2] pulses again 5 edges after Reset deasserts; no Released[2] pulse.
- BUTTON_REPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5, key 3 held 30 cycles -> Pressed[3] at t, t+10, t+15, t+20, t+25; without the macro, only at t.
